// File: rtl/keyboard_pkg.sv
// keyboard_pkg: matrix geometry, key-state bus type and scanner FSM states
package keyboard_pkg;
  localparam int KB_ROWS = 6;
  localparam int KB_COLS = 7;
  typedef logic [KB_ROWS-1:0][KB_COLS-1:0] kb_state_t;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP, UPDATE} scan_state_t;
endpackage

// File: rtl/keyboard_scanner_if.sv
// keyboard_scanner_if: keypad matrix pins plus the debounced key-state bus
interface keyboard_scanner_if;
  import keyboard_pkg::*;
  logic [KB_ROWS-1:0] rows_out;
  logic [KB_COLS-1:0] cols_in;
  kb_state_t state;
  logic frame_done;
  logic changed;
  modport master (output rows_out, state, frame_done, changed, input cols_in);
  modport slave (input rows_out, state, frame_done, changed, output cols_in);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: one key's frame-disagreement counter and debounced state bit
module key_debounce #(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic update,
  output logic state,
  output logic toggle
);
  localparam logic [3:0] DF_LAST = 4'(DEBOUNCE_FRAMES - 1);
  logic [3:0] cnt;
  assign toggle = update && raw != state && cnt == DF_LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      state <= 1'b0;
    end else if (update) begin
      cnt <= (raw == state || toggle) ? '0 : cnt + 4'd1;
      state <= state ^ toggle;
    end
endmodule

// File: rtl/keyboard_scanner.sv
// keyboard_scanner: row-strobed 6x7 keypad scanner with per-key debounce.
// Define KEYBOARD_SCANNER_GHOST_REJECT_EN to drop frames showing a ghost pattern.
module keyboard_scanner import keyboard_pkg::*; #(
  parameter int SETTLE_CYCLES = 16,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input logic clk,
  input logic rst,
  keyboard_scanner_if.master kb
);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0] SC_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [2:0] R_LAST = 3'(KB_ROWS - 1);
  scan_state_t st, nxt;
  logic [2:0] r, r_nxt;
  logic [SW-1:0] sc, sc_nxt;
  logic sample, update;
  logic [KB_COLS-1:0] s1, s2;
  logic [KB_ROWS-1:0] rows_nxt;
  kb_state_t raw, st_q, tog;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      r <= '0;
      sc <= '0;
      s1 <= '1;
      s2 <= '1;
      raw <= '0;
      kb.rows_out <= '1;
      kb.frame_done <= 1'b0;
      kb.changed <= 1'b0;
    end else begin
      st <= nxt;
      r <= r_nxt;
      sc <= sc_nxt;
      {s2, s1} <= {s1, kb.cols_in};
      if (sample) raw[r] <= ~s2;
      kb.rows_out <= rows_nxt;
      kb.frame_done <= st == UPDATE;
      kb.changed <= |tog;
    end
  // rows_out is registered from the next state so the drive is glitch-free
  always_comb begin
    nxt = st;
    r_nxt = r;
    sc_nxt = '0;
    sample = 1'b0;
    case (st)
      IDLE: nxt = DRIVE;
      DRIVE: begin
        sample = sc == SC_LAST;
        nxt = sample ? GAP : DRIVE;
        sc_nxt = sample ? '0 : sc + 1'b1;
      end
      GAP: begin
        nxt = r == R_LAST ? UPDATE : DRIVE;
        r_nxt = r == R_LAST ? '0 : r + 3'd1;
      end
      default: nxt = DRIVE;
    endcase
    rows_nxt = nxt == DRIVE ? ~(KB_ROWS'(1) << r_nxt) : '1;
  end
`ifdef KEYBOARD_SCANNER_GHOST_REJECT_EN
  logic ghost;
  always_comb begin
    ghost = 1'b0;
    for (int a = 0; a < KB_ROWS; a++)
      for (int b = a + 1; b < KB_ROWS; b++)
        if ($countones(raw[a] & raw[b]) > 1) ghost = 1'b1;
  end
  assign update = st == UPDATE && !ghost;
`else
  assign update = st == UPDATE;
`endif
  for (genvar i = 0; i < KB_ROWS; i++) begin : g_r
    for (genvar j = 0; j < KB_COLS; j++) begin : g_c
      key_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_key (
        .clk(clk),
        .rst(rst),
        .raw(raw[i][j]),
        .update(update),
        .state(st_q[i][j]),
        .toggle(tog[i][j])
      );
    end
  end
  assign kb.state = st_q;
endmodule

// File: tb/tb_keyboard_scanner.sv
// tb_keyboard_scanner: directed and random keypad frames checked against a frame-level debounce model
module tb_keyboard_scanner;
  import keyboard_pkg::*;
  localparam int DF = 3;
  logic clk = 1'b0;
  logic rst;
  kb_state_t keys;
  kb_state_t es;
  int run [KB_ROWS][KB_COLS];
  logic ec;
  int checks = 0;
  int failures = 0;
  keyboard_scanner_if kb ();
  keyboard_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_FRAMES(DF)) dut (.clk(clk), .rst(rst), .kb(kb));
  always #5 clk = ~clk;
  // physical matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    kb.cols_in = '1;
    for (int r = 0; r < KB_ROWS; r++)
      if (!kb.rows_out[r]) kb.cols_in = kb.cols_in & ~keys[r];
  end
  task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [5:0] exp_rows(input int p);
    return (p < 30 && p % 5 < 4) ? ~(6'd1 << (p / 5)) : 6'h3F;
  endfunction
  task automatic model_reset();
    es = '0;
    ec = 1'b0;
    foreach (run[r, c]) run[r][c] = 0;
  endtask
  task automatic model_update(input kb_state_t m);
    bit ghost;
    ghost = 1'b0;
    ec = 1'b0;
`ifdef KEYBOARD_SCANNER_GHOST_REJECT_EN
    for (int a = 0; a < KB_ROWS; a++)
      for (int b = a + 1; b < KB_ROWS; b++)
        if ($countones(m[a] & m[b]) >= 2) ghost = 1'b1;
`endif
    if (!ghost)
      foreach (run[r, c])
        if (m[r][c] == es[r][c]) run[r][c] = 0;
        else if (run[r][c] + 1 == DF) begin
          es[r][c] = ~es[r][c];
          run[r][c] = 0;
          ec = 1'b1;
        end else run[r][c]++;
  endtask
  // entered and left at the falling edge of a frame's first cycle
  task automatic run_frame(input kb_state_t m);
    keys = m;
    for (int p = 1; p < 31; p++) begin
      @(negedge clk);
      chk("rows", kb.rows_out, exp_rows(p));
      chk("one_low", $countones(~kb.rows_out) <= 1, 1);
      chk("fd_idle", kb.frame_done, 0);
      chk("chg_idle", kb.changed, 0);
      chk("state_hold", kb.state, es);
    end
    model_update(m);
    @(negedge clk);
    chk("rows_p0", kb.rows_out, exp_rows(0));
    chk("fd_pulse", kb.frame_done, 1);
    chk("state_upd", kb.state, es);
    chk("chg_upd", kb.changed, ec);
  endtask
  kb_state_t m, m0, mg;
  initial begin
    rst = 1'b1;
    keys = '0;
    m0 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rows", kb.rows_out, 6'h3F);
    chk("rst_state", kb.state, 0);
    chk("rst_fd", kb.frame_done, 0);
    chk("rst_chg", kb.changed, 0);
    m = '0;
    m[2][5] = 1'b1;
    keys = m;
    rst = 1'b0;
    #1 chk("idle_rows", kb.rows_out, 6'h3F);
    @(negedge clk);
    chk("first_rows", kb.rows_out, 6'h3E);
    chk("first_fd", kb.frame_done, 0);
    run_frame(m);
    run_frame(m);
    chk("k25_f2", kb.state[2][5], 0);
    run_frame(m);
    chk("k25_f3", kb.state, m);
    chk("k25_chg", kb.changed, 1);
    repeat (3) run_frame(m0);
    chk("k25_rel", kb.state, 0);
    repeat (2) run_frame(m);
    repeat (4) run_frame(m0);
    chk("glitch", kb.state, 0);
    m = '0;
    m[4][0] = 1'b1;
    repeat (3) run_frame(m);
    chk("k40_on", kb.state[4][0], 1);
    repeat (2) run_frame(m0);
    chk("k40_hold", kb.state[4][0], 1);
    run_frame(m0);
    chk("k40_off", kb.state[4][0], 0);
    mg = '0;
    mg[1][2] = 1'b1;
    mg[1][3] = 1'b1;
    mg[3][2] = 1'b1;
    mg[3][3] = 1'b1;
    repeat (3) run_frame(mg);
`ifdef KEYBOARD_SCANNER_GHOST_REJECT_EN
    chk("ghost_state", kb.state, 0);
    chk("ghost_chg", kb.changed, 0);
`else
    chk("ghost_state", kb.state, mg);
    chk("ghost_chg", kb.changed, 1);
`endif
    repeat (3) run_frame(m0);
    m = '0;
    for (int f = 0; f < 24; f++) begin
      repeat ($urandom_range(0, 2)) m[$urandom_range(0, 5)][$urandom_range(0, 6)] ^= 1'b1;
      run_frame(m);
    end
    m = '0;
    m[0][6] = 1'b1;
    repeat (3) run_frame(m);
    chk("k06_on", kb.state[0][6], 1);
    m = '0;
    m[1][1] = 1'b1;
    keys = m;
    repeat (16) @(negedge clk);
    chk("mid_row3", kb.rows_out, 6'h37);
    #2 rst = 1'b1;
    #1 chk("arst_rows", kb.rows_out, 6'h3F);
    chk("arst_state", kb.state, 0);
    chk("arst_fd", kb.frame_done, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_rows", kb.rows_out, 6'h3E);
    repeat (2) run_frame(m);
    chk("k11_f2", kb.state, 0);
    run_frame(m);
    chk("k11_f3", kb.state, m);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keyboard_scanner.md
# keyboard_scanner

- Scans a physical 6×7 payphone keypad matrix and produces a debounced pressed-key map, `state[row][col]`, with 1 meaning pressed.
- Drives one row low at a time, samples the active-low column returns, and filters each key over several full scan frames.
- Sits on the real-keyboard side of the converter and feeds the key-state bus consumed by the emulator that answers the payphone's own row strobes.

## Interface
- `SETTLE_CYCLES`, default 16: clocks each row is held low before its columns are sampled; minimum 3.
- `DEBOUNCE_FRAMES`, default 4: consecutive disagreeing frames needed before a key flips; range 1–15.
- `clk`  in  1  single system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rows_out`  out  6  row drive, active-low; at most one bit low at any time.
- `cols_in`  in  7  column returns, active-low, asynchronous to `clk`.
- `state`  out  6×7 (`[5:0][6:0]`)  debounced key map, 1 = pressed.
- `frame_done`  out  1  one-cycle pulse each time a frame's debounce update is applied.
- `changed`  out  1  one-cycle pulse, coincident with `frame_done`, when any `state` bit flipped on that update.

## Operation
- `cols_in` passes through a 2-flop synchronizer, then is inverted so that 1 = pressed.
- FSM states:
  - IDLE: entered on reset; moves to DRIVE on the first clock after reset.
  - DRIVE: `rows_out[r]` low, settle counter runs from 0 to SETTLE_CYCLES−1. On the final count, the synchronized columns are stored into `raw[r]`, then the FSM goes to GAP.
  - GAP: one cycle with all rows high. If r < 5: r++ and back to DRIVE. If r == 5: r = 0 and go to UPDATE.
  - UPDATE: one cycle; applies the debounce update, then goes to DRIVE with row 0.
- Per-key 4-bit saturating counter `cnt[r][c]`, evaluated in UPDATE:
  - `raw == state`: cnt ← 0.
  - Otherwise, cnt + 1 == DEBOUNCE_FRAMES: `state` bit toggles and cnt ← 0.
  - Otherwise: cnt ← cnt + 1.
- `raw` is overwritten each frame and is never cleared between frames.

## Timing
- Reset values: `rows_out` = 6'b111111, `state` = 0, `frame_done` = 0, `changed` = 0, all counters and `raw` = 0, r = 0, FSM = IDLE.
- Frame length is 6·(SETTLE_CYCLES+1)+1 clocks.
- `state`, `frame_done` and `changed` all update on the clock edge that leaves UPDATE.
- The sample instant is the last DRIVE cycle. Because of the synchronizer, the column level must be stable from DRIVE cycle SETTLE_CYCLES−3 onward.
- A steady press appears in `state` at the end of frame DEBOUNCE_FRAMES after the first frame that samples it. Release behaves symmetrically.
- A glitch shorter than DEBOUNCE_FRAMES frames never reaches `state`.
- Asserting `rst` mid-frame immediately releases all rows (asynchronous) and discards the partial `raw` data. Scanning restarts at row 0.
- `rows_out` never has two bits low, including across the DRIVE→GAP→DRIVE transition.

## Configuration
- `KEYBOARD_SCANNER_GHOST_REJECT_EN`:
  - Defined: in UPDATE, the frame is checked for the ghost pattern, i.e. any two rows whose `raw` vectors share two or more set columns (popcount of `raw[a] & raw[b]` ≥ 2). If found, the whole frame is ignored: counters and `state` are unchanged, `frame_done` still pulses, and `changed` = 0.
  - Undefined: every frame is applied unconditionally and no ghost logic is synthesized.

## Structure
- Shared package `keyboard_pkg`:
  - `KB_ROWS` = 6 and `KB_COLS` = 7.
  - `kb_state_t` (`logic [KB_ROWS-1:0][KB_COLS-1:0]`), also used by the emulator's state input.
  - The scanner FSM state enum.
- One sub-module, `key_debounce`: a single key's counter and state bit, with inputs `raw`, `update` and `DEBOUNCE_FRAMES`. It is instantiated 42 times in a generate loop.

## Test plan
All scenarios use SETTLE_CYCLES = 4 and DEBOUNCE_FRAMES = 3, giving a 31-clock frame.
- Reset → `rows_out` = 6'h3F and `state` = 0 immediately. After release, the row-low sequence is 0..5 for 4 clocks each, each followed by a 1-clock all-high gap. `frame_done` pulses every 31 clocks.
- Key (2,5) held pressed from before frame 1 → `state[2][5]` = 1 and `changed` = 1 at the end of frame 3, with no other bits set. `state[2][5]` is still 0 after frame 2.
- Key (2,5) pressed for 2 frames and then released → `state` stays 0 throughout and `changed` never pulses.
- Key (4,0) released after being debounced as pressed → `state[4][0]` = 0 exactly 3 frames later.
- With the macro defined, keys (1,2), (1,3), (3,2) and (3,3) all pressed → `state` unchanged, `frame_done` pulses and `changed` = 0. Without the macro, all four keys set after 3 frames.
- `rst` pulsed mid-way through row 3 → rows release asynchronously, `state` = 0, and scanning restarts at row 0 on the next frame.
